// File: rtl/team_06_i2s_tx.sv
// team_06_i2s_tx
// I2S-style serial transmitter for the audio DAC path. Accepts 8-bit samples
// over a valid/ready handshake into a one-deep holding register. Each 16-bit
// frame sends that sample MSB first in both the left and the right slot. The
// bit clock is derived from clk. Data and word select change only on bit-clock
// falling edges, so a rising-edge sampler in the DAC captures them cleanly.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous, active-high reset
//   sample_in     8-bit unsigned sample
//   sample_valid  sample_in valid this cycle
//   sample_ready  holding register empty (transfer on valid && ready)
//   i2s_sclk      bit clock, period 2*CLK_DIV clk cycles
//   i2s_ws        word select, 0 = left slot, 1 = right slot
//   i2s_sd        serial data, MSB first
//   frame_start   one-cycle pulse when a frame is loaded
//   underrun      one-cycle pulse when a frame loads with no sample held
//
// Parameter
//   CLK_DIV       clk cycles per bit-clock half period, 2..255

module team_06_i2s_tx #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] sample_in,
   input  logic       sample_valid,
   output logic       sample_ready,
   output logic       i2s_sclk,
   output logic       i2s_ws,
   output logic       i2s_sd,
   output logic       frame_start,
   output logic       underrun
);

   localparam int unsigned DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] r_div_cnt;
   logic          r_sclk;
   logic [3:0]    r_idx;
   logic [7:0]    r_hold;
   logic          r_hold_full;
   logic [7:0]    r_frame;
   logic          r_ws;
   logic          r_sd;
   logic          r_frame_start;
   logic          r_underrun;

   logic          w_toggle;
   logic          w_fall;
   logic [3:0]    w_idx_next;
   logic          w_load;
   logic          w_accept;
   logic [7:0]    w_frame_next;
   logic          w_sd_next;
   logic          w_ws_next;

   assign w_toggle   = (r_div_cnt == DIV_LAST);
   // The toggle cycle while sclk is high is the falling edge of the bit clock.
   assign w_fall     = w_toggle & r_sclk;
   assign w_idx_next = r_idx + 4'd1;
   // The frame boundary is the fall event where the bit index wraps 15 -> 0.
   assign w_load     = w_fall & (w_idx_next == 4'd0);
   assign w_accept   = sample_valid & ~r_hold_full;

   // The load looks only at the pre-edge hold state: a sample accepted on the
   // load edge waits for the next frame, and this frame carries zeros.
   always_comb begin
      w_frame_next = r_frame;
      if (w_load) begin
         w_frame_next = r_hold_full ? r_hold : 8'h00;
      end
   end

   // Bit 7 - (k mod 8) equals the inverted low three bits of k. The newly
   // loaded frame is used, so the MSB appears at the load edge itself.
   assign w_sd_next = w_frame_next[~w_idx_next[2:0]];
   // WS leads each slot by one bit period: high for k = 7..14.
   assign w_ws_next = (w_idx_next >= 4'd7) && (w_idx_next <= 4'd14);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div_cnt     <= '0;
         r_sclk        <= 1'b0;
         r_idx         <= 4'd15;
         r_hold        <= 8'h00;
         r_hold_full   <= 1'b0;
         r_frame       <= 8'h00;
         r_ws          <= 1'b0;
         r_sd          <= 1'b0;
         r_frame_start <= 1'b0;
         r_underrun    <= 1'b0;
      end else begin
         r_frame_start <= 1'b0;
         r_underrun    <= 1'b0;

         if (w_toggle) begin
            r_div_cnt <= '0;
            r_sclk    <= ~r_sclk;
         end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
         end

         if (w_fall) begin
            r_idx <= w_idx_next;
            r_sd  <= w_sd_next;
            r_ws  <= w_ws_next;
         end

         if (w_load) begin
            r_frame       <= w_frame_next;
            r_frame_start <= 1'b1;
            r_underrun    <= ~r_hold_full;
         end

         // Accept only happens while empty, and a load only drains while full,
         // so the two never compete for r_hold_full in the same cycle.
         if (w_accept) begin
            r_hold      <= sample_in;
            r_hold_full <= 1'b1;
         end else if (w_load && r_hold_full) begin
            r_hold_full <= 1'b0;
         end
      end
   end

   assign sample_ready = ~r_hold_full;
   assign i2s_sclk     = r_sclk;
   assign i2s_ws       = r_ws;
   assign i2s_sd       = r_sd;
   assign frame_start  = r_frame_start;
   assign underrun     = r_underrun;

endmodule

// File: tb/tb_team_06_i2s_tx.sv
module tb_team_06_i2s_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid = 1'b0;
   logic [7:0] din = 8'h00;

   logic rdy2, sclk2, ws2, sd2, fs2, ur2;
   logic rdy5, sclk5, ws5, sd5, fs5, ur5;

   always #5 clk = ~clk;

   team_06_i2s_tx #(.CLK_DIV(2)) u2 (
      .clk(clk), .rst(rst), .sample_in(din), .sample_valid(valid),
      .sample_ready(rdy2), .i2s_sclk(sclk2), .i2s_ws(ws2), .i2s_sd(sd2),
      .frame_start(fs2), .underrun(ur2));

   team_06_i2s_tx #(.CLK_DIV(5)) u5 (
      .clk(clk), .rst(rst), .sample_in(din), .sample_valid(valid),
      .sample_ready(rdy5), .i2s_sclk(sclk5), .i2s_ws(ws5), .i2s_sd(sd5),
      .frame_start(fs5), .underrun(ur5));

   // Reference: m = clk edges since reset released. The bit clock toggles
   // every d edges, a fall event occurs every 2*d edges, and fall number f
   // carries bit index (f-1) mod 16; index 0 is a frame load.
   typedef struct {
      int         m;
      bit         full;
      logic [7:0] hold;
      logic [7:0] frame;
      bit         sd;
      bit         ws;
      bit         fs;
      bit         ur;
   } mdl_t;

   function automatic mdl_t mreset();
      mdl_t n;
      n.m = 0; n.full = 0; n.hold = 8'h00; n.frame = 8'h00;
      n.sd = 0; n.ws = 0; n.fs = 0; n.ur = 0;
      return n;
   endfunction

   function automatic mdl_t mstep(mdl_t s, int d, bit r, bit v, logic [7:0] x);
      mdl_t n;
      int   f;
      int   k;
      if (r) return mreset();
      n = s;
      n.fs = 0;
      n.ur = 0;
      n.m = s.m + 1;
      if (n.m % (2 * d) == 0) begin
         f = n.m / (2 * d);
         k = (f - 1) % 16;
         if (k == 0) begin
            n.fs = 1;
            if (s.full) begin
               n.frame = s.hold;
               n.full = 0;
            end else begin
               n.frame = 8'h00;
               n.ur = 1;
            end
         end
         n.sd = n.frame[7 - (k % 8)];
         n.ws = (k >= 7) && (k <= 14);
      end
      if (v && !s.full) begin
         n.hold = x;
         n.full = 1;
      end
      return n;
   endfunction

   mdl_t       m2;
   mdl_t       m5;
   int         tests = 0;
   int         fails = 0;
   logic [31:0] cap = '0;
   logic       prev_sclk2 = 1'b0;
   int         cyc5 = 0;
   int         last5 = -1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_dut(input string nm, input mdl_t s, input int d,
                          input logic sclk, input logic ws, input logic sd,
                          input logic rdy, input logic fs, input logic ur);
      chk({nm, "_sclk"},  {31'd0, sclk}, {31'd0, ((s.m / d) % 2) == 1});
      chk({nm, "_ws"},    {31'd0, ws},   {31'd0, s.ws});
      chk({nm, "_sd"},    {31'd0, sd},   {31'd0, s.sd});
      chk({nm, "_ready"}, {31'd0, rdy},  {31'd0, !s.full});
      chk({nm, "_fs"},    {31'd0, fs},   {31'd0, s.fs});
      chk({nm, "_ur"},    {31'd0, ur},   {31'd0, s.ur});
   endtask

   // One clk cycle: drive inputs at the negedge, advance the reference at the
   // posedge, compare at the following negedge.
   task automatic step(input bit r, input bit v, input logic [7:0] x);
      rst = r;
      valid = v;
      din = x;
      @(posedge clk);
      m2 = mstep(m2, 2, r, v, x);
      m5 = mstep(m5, 5, r, v, x);
      @(negedge clk);
      chk_dut("d2", m2, 2, sclk2, ws2, sd2, rdy2, fs2, ur2);
      chk_dut("d5", m5, 5, sclk5, ws5, sd5, rdy5, fs5, ur5);
      if (!prev_sclk2 && sclk2) cap = {cap[30:0], sd2};
      prev_sclk2 = sclk2;
      if (r) begin
         cyc5 = 0;
         last5 = -1;
      end else begin
         cyc5++;
         if (fs5) begin
            if (last5 >= 0) chk("d5_frame_period", cyc5 - last5, 160);
            last5 = cyc5;
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 8'h00);
   endtask

   task automatic do_reset();
      step(1, 0, 8'h00);
      step(1, 0, 8'h00);
   endtask

   initial begin
      int wcnt;
      int urc;
      m2 = mreset();
      m5 = mreset();

      // Start-up with no samples: sclk rises at m=2, falls at m=4 with an
      // underrun frame; sd stays 0.
      do_reset();
      chk("rst_sclk",  {31'd0, sclk2}, 0);
      chk("rst_ready", {31'd0, rdy2},  1);
      chk("rst_sd",    {31'd0, sd2},   0);
      run(3);
      chk("startup_fs", {31'd0, fs2}, 0);
      step(0, 0, 8'h00);
      chk("startup_fs4", {31'd0, fs2}, 1);
      chk("startup_ur4", {31'd0, ur2}, 1);
      cap = '0;
      run(64);
      chk("startup_sd_zero", cap, 0);

      // Single sample 0xA5, mono-duplicated.
      do_reset();
      step(0, 1, 8'hA5);
      run(3);
      chk("a5_fs", {31'd0, fs2}, 1);
      chk("a5_ur", {31'd0, ur2}, 0);
      chk("a5_msb_at_load", {31'd0, sd2}, 1);
      cap = '0;
      run(64);
      chk("a5_bits", {16'd0, cap[15:0]}, 32'h0000A5A5);

      // Backpressure: 0x3C then 0xC3 offered immediately.
      do_reset();
      step(0, 1, 8'h3C);
      wcnt = 0;
      while (!rdy2 && wcnt < 100) begin
         step(0, 1, 8'hC3);
         wcnt++;
      end
      chk("bp_wait_cycles", wcnt, 3);
      step(0, 1, 8'hC3);
      chk("bp_c3_accepted", {31'd0, rdy2}, 0);
      cap = '0;
      run(127);
      chk("bp_frames", cap, 32'h3C3CC3C3);

      // Accept on the load edge with an empty hold register.
      do_reset();
      run(3);
      step(0, 1, 8'hFF);
      chk("sim_ur", {31'd0, ur2}, 1);
      chk("sim_held", {31'd0, rdy2}, 0);
      cap = '0;
      run(64);
      chk("sim_zero_frame", {16'd0, cap[15:0]}, 0);
      cap = '0;
      run(64);
      chk("sim_ff_frame", {16'd0, cap[15:0]}, 32'h0000FFFF);

      // Reset mid-frame after five bits of 0x81.
      do_reset();
      step(0, 1, 8'h81);
      run(23);
      step(1, 0, 8'h00);
      chk("mid_sclk",  {31'd0, sclk2}, 0);
      chk("mid_ws",    {31'd0, ws2},   0);
      chk("mid_sd",    {31'd0, sd2},   0);
      chk("mid_ready", {31'd0, rdy2},  1);
      chk("mid_fs",    {31'd0, fs2},   0);
      chk("mid_ur",    {31'd0, ur2},   0);
      urc = 0;
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 8'h00);
         if (ur2 === 1'b1) urc++;
      end
      chk("mid_next_underrun", urc, 1);

      // Randomized traffic, checked on both divider settings every cycle.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 999) == 0), ($urandom_range(0, 9) == 0),
              8'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
